// File: rtl/lifo_pkg.sv
// -----------------------------------------------------------------------------
// lifo_pkg
// Shared definitions for the stack and future FIFO/stack variants.
//   OP_* : decoded {push, pop} operation codes (after chip-select gating)
//   lifo_clog2 : ceiling log2, used for count and address widths
// -----------------------------------------------------------------------------
package lifo_pkg;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    function automatic int lifo_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lifo_ram.sv
// -----------------------------------------------------------------------------
// lifo_ram
// WIDTH x DEPTH storage array for the stack. Contents are not reset.
// Ports:
//   clk   in  : write clock
//   we    in  : write enable
//   waddr in  : write address
//   wdata in  : write data
//   raddr in  : asynchronous read address
//   rdata out : asynchronous read data
// -----------------------------------------------------------------------------
module lifo_ram
    import lifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = lifo_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
// Parametrised chip-select gated LIFO with simultaneous push/pop (swap),
// registered pop data, occupancy status and one-cycle error pulses.
// Optional macro LIFO_PEEK_EN adds the combinational 'top' output.
// Ports:
//   clk        in  : clock
//   reset      in  : asynchronous active-low reset
//   cs         in  : chip select, gates push/pop
//   push, pop  in  : operation strobes
//   datain     in  : push data
//   dataout    out : registered pop data
//   dout_valid out : dataout updated this cycle
//   count      out : occupancy 0..DEPTH
//   full/empty out : decoded from count
//   overflow   out : push dropped while full (pulse)
//   underflow  out : pop rejected while empty (pulse)
//   top        out : current top of stack, 0 when empty (LIFO_PEEK_EN only)
// -----------------------------------------------------------------------------
module lifo_stack
    import lifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = lifo_clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
`ifdef LIFO_PEEK_EN
    output logic [WIDTH-1:0] top,
`endif
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = lifo_clog2(DEPTH);

    logic [1:0]       op;
    logic             we;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] rdata;

    assign op       = {cs & push, cs & pop};
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_idx = AW'(count);
    // Wraps to the last index when empty; the read is then unused.
    assign top_idx  = AW'(count - CW'(1));

    // Plain push writes above the top; swap overwrites the top in place.
    always_comb begin
        we    = 1'b0;
        waddr = push_idx;
        case (op)
            OP_PUSH: begin
                we    = ~full;
                waddr = push_idx;
            end
            OP_SWAP: begin
                we    = ~empty;
                waddr = top_idx;
            end
            default: begin
                we    = 1'b0;
                waddr = push_idx;
            end
        endcase
    end

    lifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (datain),
        .raddr (top_idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            dataout    <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        dataout    <= rdata;
                        dout_valid <= 1'b1;
                        count      <= count - CW'(1);
                    end
                end
                OP_SWAP: begin
                    // Empty swap bypasses storage entirely.
                    dataout    <= empty ? datain : rdata;
                    dout_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LIFO_PEEK_EN
    assign top = empty ? '0 : rdata;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
// Directed bench for lifo_stack with WIDTH=8, DEPTH=4.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

    logic       clk;
    logic       reset;
    logic       cs;
    logic       push;
    logic       pop;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic       dout_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;
`ifdef LIFO_PEEK_EN
    logic [7:0] top;
`endif

    int passed;
    int total;

    lifo_stack #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .push       (push),
        .pop        (pop),
        .datain     (datain),
        .dataout    (dataout),
        .dout_valid (dout_valid),
        .count      (count),
`ifdef LIFO_PEEK_EN
        .top        (top),
`endif
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given strobes, then strobes dropped at the falling edge.
    task automatic do_op(input logic p, input logic q, input logic [7:0] d, input logic c);
        cs     = c;
        push   = p;
        pop    = q;
        datain = d;
        @(posedge clk);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        cs   = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        cs = 1'b1; push = 1'b0; pop = 1'b0; datain = 8'h00;
        @(negedge clk);
        @(negedge clk);
        total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        total++; if ({full, empty} !== 2'b01) $display("FAIL reset_flags: got full=%b empty=%b want 0/1", full, empty); else passed++;
        total++; if ({dout_valid, overflow, underflow} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {dout_valid, overflow, underflow}); else passed++;
        reset = 1'b1;
        @(negedge clk);
        do_op(1, 0, 8'h11, 1);
        do_op(1, 0, 8'h22, 1);
        do_op(1, 0, 8'h33, 1);
        do_op(1, 0, 8'h44, 1);
        do_op(0, 1, 8'h00, 1);
        total++; if (count !== 3'd3 || dataout !== 8'h44) $display("FAIL pre_reset: got count=%0d data=%h want 3/44", count, dataout); else passed++;
        // Async reset mid-traffic, push held through the release.
        push = 1'b1; datain = 8'h66;
        #2 reset = 1'b0;
        #1;
        total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL async_reset: got count=%0d empty=%b want 0/1", count, empty); else passed++;
        total++; if (dataout !== 8'h00 || dout_valid !== 1'b0) $display("FAIL async_reset_out: got data=%h valid=%b want 00/0", dataout, dout_valid); else passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push = 1'b0;
        total++; if (count !== 3'd1) $display("FAIL post_reset_push: got count=%0d want 1", count); else passed++;
        do_op(0, 1, 8'h00, 1);
        total++; if (dataout !== 8'h66 || empty !== 1'b1) $display("FAIL post_reset_pop: got data=%h empty=%b want 66/1", dataout, empty); else passed++;
    endtask

    task automatic test_push_pop;
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            do_op(1, 0, vals[i], 1);
            total++; if (count !== 3'(i + 1)) $display("FAIL push_count%0d: got %0d want %0d", i, count, i + 1); else passed++;
`ifdef LIFO_PEEK_EN
            total++; if (top !== vals[i]) $display("FAIL peek%0d: got %h want %h", i, top, vals[i]); else passed++;
`endif
        end
        total++; if (full !== 1'b1 || empty !== 1'b0) $display("FAIL full_flag: got full=%b empty=%b want 1/0", full, empty); else passed++;
        for (int i = 3; i >= 0; i--) begin
            do_op(0, 1, 8'h00, 1);
            total++; if (dataout !== vals[i] || dout_valid !== 1'b1) $display("FAIL pop%0d: got data=%h valid=%b want %h/1", i, dataout, dout_valid, vals[i]); else passed++;
        end
        total++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL empty_flag: got empty=%b count=%0d want 1/0", empty, count); else passed++;
        do_op(0, 0, 8'h00, 1);
        total++; if (dout_valid !== 1'b0 || dataout !== 8'h11) $display("FAIL idle_hold: got valid=%b data=%h want 0/11", dout_valid, dataout); else passed++;
    endtask

    task automatic test_overflow;
        do_op(1, 0, 8'h11, 1);
        do_op(1, 0, 8'h22, 1);
        do_op(1, 0, 8'h33, 1);
        do_op(1, 0, 8'h44, 1);
        do_op(1, 0, 8'h55, 1);
        total++; if (overflow !== 1'b1 || count !== 3'd4) $display("FAIL overflow: got ovf=%b count=%0d want 1/4", overflow, count); else passed++;
        do_op(0, 0, 8'h00, 1);
        total++; if (overflow !== 1'b0) $display("FAIL overflow_pulse: got %b want 0", overflow); else passed++;
        do_op(0, 1, 8'h00, 1);
        total++; if (dataout !== 8'h44 || count !== 3'd3) $display("FAIL pop_after_ovf: got data=%h count=%0d want 44/3", dataout, count); else passed++;
        do_op(0, 1, 8'h00, 1);
        do_op(0, 1, 8'h00, 1);
        do_op(0, 1, 8'h00, 1);
    endtask

    task automatic test_underflow;
        do_op(0, 1, 8'h00, 1);
        total++; if (underflow !== 1'b1 || dout_valid !== 1'b0) $display("FAIL underflow: got unf=%b valid=%b want 1/0", underflow, dout_valid); else passed++;
        total++; if (dataout !== 8'h11 || count !== 3'd0) $display("FAIL underflow_hold: got data=%h count=%0d want 11/0", dataout, count); else passed++;
        do_op(0, 0, 8'h00, 1);
        total++; if (underflow !== 1'b0) $display("FAIL underflow_pulse: got %b want 0", underflow); else passed++;
    endtask

    task automatic test_swap;
        do_op(1, 0, 8'h11, 1);
        do_op(1, 0, 8'h22, 1);
        do_op(1, 1, 8'h99, 1);
        total++; if (dataout !== 8'h22 || dout_valid !== 1'b1 || count !== 3'd2) $display("FAIL swap: got data=%h valid=%b count=%0d want 22/1/2", dataout, dout_valid, count); else passed++;
        do_op(0, 1, 8'h00, 1);
        total++; if (dataout !== 8'h99) $display("FAIL swap_pop: got %h want 99", dataout); else passed++;
        do_op(1, 0, 8'h33, 1);
        do_op(1, 0, 8'h44, 1);
        do_op(1, 0, 8'h55, 1);
        do_op(1, 1, 8'h77, 1);
        total++; if (dataout !== 8'h55 || overflow !== 1'b0 || count !== 3'd4) $display("FAIL swap_full: got data=%h ovf=%b count=%0d want 55/0/4", dataout, overflow, count); else passed++;
        do_op(0, 1, 8'h00, 1);
        total++; if (dataout !== 8'h77) $display("FAIL swap_full_pop: got %h want 77", dataout); else passed++;
        do_op(0, 1, 8'h00, 1);
        do_op(0, 1, 8'h00, 1);
        do_op(0, 1, 8'h00, 1);
        total++; if (dataout !== 8'h11 || empty !== 1'b1) $display("FAIL swap_drain: got data=%h empty=%b want 11/1", dataout, empty); else passed++;
    endtask

    task automatic test_bypass_cs;
        do_op(1, 1, 8'hA5, 1);
        total++; if (dataout !== 8'hA5 || dout_valid !== 1'b1 || count !== 3'd0) $display("FAIL bypass: got data=%h valid=%b count=%0d want a5/1/0", dataout, dout_valid, count); else passed++;
        total++; if ({overflow, underflow} !== 2'b00) $display("FAIL bypass_flags: got %b want 00", {overflow, underflow}); else passed++;
        do_op(1, 0, 8'h5A, 0);
        total++; if (count !== 3'd0 || dout_valid !== 1'b0) $display("FAIL cs_push: got count=%0d valid=%b want 0/0", count, dout_valid); else passed++;
        do_op(1, 0, 8'h3C, 1);
        do_op(0, 1, 8'h00, 0);
        total++; if (count !== 3'd1 || dout_valid !== 1'b0 || dataout !== 8'hA5) $display("FAIL cs_pop: got count=%0d valid=%b data=%h want 1/0/a5", count, dout_valid, dataout); else passed++;
`ifdef LIFO_PEEK_EN
        total++; if (top !== 8'h3C) $display("FAIL peek_top: got %h want 3c", top); else passed++;
`endif
        do_op(0, 1, 8'h00, 1);
        total++; if (dataout !== 8'h3C || count !== 3'd0) $display("FAIL cs_final_pop: got data=%h count=%0d want 3c/0", dataout, count); else passed++;
`ifdef LIFO_PEEK_EN
        total++; if (top !== 8'h00) $display("FAIL peek_empty: got %h want 00", top); else passed++;
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_swap();
        test_bypass_cs();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
